// File: rtl/video_timing.sv
// Raster timing generator: walks pixel/row counters with logical-line repetition
// and emits registered position, look-ahead, sync, visibility and vblank signals.
module video_timing #(
  parameter int H_VISIBLE   = 256,
  parameter int H_FRONT     = 8,
  parameter int H_SYNC      = 32,
  parameter int H_BACK      = 24,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 31,
  parameter int NUM_ROWS    = 523,
  parameter int LINE_REPEAT = 2
) (
  input  logic       gpu_clk,
  input  logic       rst,
  output logic [8:0] current_x,
  output logic [8:0] current_y,
  output logic [8:0] next_x,
  output logic [8:0] next_y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       vblank_irq,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int MAX_Y    = (NUM_ROWS + LINE_REPEAT - 1) / LINE_REPEAT;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int RW       = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
  localparam int PW       = (LINE_REPEAT > 2) ? $clog2(LINE_REPEAT) : 1;

  if (V_VISIBLE + V_FRONT + V_SYNC + V_BACK != NUM_ROWS) begin : g_bad_rows
    $error("video_timing: vertical parameters do not sum to NUM_ROWS");
  end
  if (LINE_REPEAT < 2) begin : g_bad_repeat
    $error("video_timing: LINE_REPEAT must be at least 2");
  end
  if (H_TOTAL > 512) begin : g_bad_htotal
    $error("video_timing: H_TOTAL exceeds 512");
  end
  if (MAX_Y > 511) begin : g_bad_maxy
    $error("video_timing: MAX_Y exceeds 511");
  end

  logic [8:0]    hcount_q, hcount_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] rep_q, rep_d;
  logic [8:0]    y_q, y_d;

  logic [8:0] current_x_q, current_x_d;
  logic [8:0] current_y_q, current_y_d;
  logic [8:0] next_x_q, next_x_d;
  logic [8:0] next_y_q, next_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       visible_q, visible_d;
  logic       vblank_irq_q, vblank_irq_d;
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    hcount_d = hcount_q + 9'd1;
    row_d    = row_q;
    rep_d    = rep_q;
    y_d      = y_q;
    if (hcount_q == 9'(H_TOTAL - 1)) begin
      hcount_d = '0;
      if (row_q == RW'(NUM_ROWS - 1)) begin
        row_d = '0;
        rep_d = '0;
        y_d   = '0;
      end else begin
        row_d = row_q + RW'(1);
        if (rep_q == PW'(LINE_REPEAT - 1)) begin
          rep_d = '0;
          y_d   = y_q + 9'd1;
        end else begin
          rep_d = rep_q + PW'(1);
        end
      end
    end
  end

  // Outputs are decoded from the counters' next values so that, once
  // registered, every output describes the same position as the counters.
  always_comb begin
    current_x_d = hcount_d;
    current_y_d = y_d;
    next_x_d    = (hcount_d == 9'(H_TOTAL - 1)) ? 9'd0 : hcount_d + 9'd1;
    if (row_d == RW'(NUM_ROWS - 1)) begin
      next_y_d = 9'(MAX_Y);
    end else if (rep_d == PW'(LINE_REPEAT - 1)) begin
      next_y_d = y_d + 9'd1;
    end else begin
      next_y_d = y_d;
    end
    hsync_d      = !((hcount_d >= 9'(HS_START)) && (hcount_d <= 9'(HS_END)));
    vsync_d      = !((row_d >= RW'(VS_START)) && (row_d <= RW'(VS_END)));
    visible_d    = (hcount_d < 9'(H_VISIBLE)) && (row_d < RW'(V_VISIBLE));
    vblank_irq_d = (hcount_d == 9'd0) && (row_d == RW'(V_VISIBLE));
    frame_count_d = vblank_irq_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= '0;
      row_q         <= '0;
      rep_q         <= '0;
      y_q           <= '0;
      current_x_q   <= '0;
      current_y_q   <= '0;
      next_x_q      <= 9'd1;
      next_y_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      visible_q     <= 1'b1;
      vblank_irq_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hcount_q      <= hcount_d;
      row_q         <= row_d;
      rep_q         <= rep_d;
      y_q           <= y_d;
      current_x_q   <= current_x_d;
      current_y_q   <= current_y_d;
      next_x_q      <= next_x_d;
      next_y_q      <= next_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      vblank_irq_q  <= vblank_irq_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign current_x   = current_x_q;
  assign current_y   = current_y_q;
  assign next_x      = next_x_q;
  assign next_y      = next_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign vblank_irq  = vblank_irq_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench: a default-parameter instance for line-level timing and a
// small-parameter instance (LINE_REPEAT=3) for frame-level behaviour.
module tb_video_timing;

  localparam int SH_TOTAL  = 16;
  localparam int SH_VIS    = 8;
  localparam int SHS_START = 10;
  localparam int SHS_END   = 12;
  localparam int S_ROWS    = 11;
  localparam int S_LR      = 3;
  localparam int S_VVIS    = 6;
  localparam int SVS_START = 7;
  localparam int SVS_END   = 8;
  localparam int S_MAXY    = 4;
  localparam int S_FRAME   = SH_TOTAL * S_ROWS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [8:0] cx, cy, nx, ny;
  logic       hs, vs, vis, irq;
  logic [7:0] fc;
  logic [8:0] s_cx, s_cy, s_nx, s_ny;
  logic       s_hs, s_vs, s_vis, s_irq;
  logic [7:0] s_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_timing dut (
    .gpu_clk(clk), .rst(rst),
    .current_x(cx), .current_y(cy), .next_x(nx), .next_y(ny),
    .hsync(hs), .vsync(vs), .visible(vis), .vblank_irq(irq), .frame_count(fc)
  );

  video_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .NUM_ROWS(11), .LINE_REPEAT(3)
  ) dut_s (
    .gpu_clk(clk), .rst(rst),
    .current_x(s_cx), .current_y(s_cy), .next_x(s_nx), .next_y(s_ny),
    .hsync(s_hs), .vsync(s_vs), .visible(s_vis), .vblank_irq(s_irq), .frame_count(s_fc)
  );

  task automatic release_rst;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic async_reset;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(2);
    release_rst();
    step(7);
    async_reset();
    checks += 10;
    if (cx !== 9'd0)  begin errors++; $display("FAIL reset_cx got %0d want 0", cx); end
    if (cy !== 9'd0)  begin errors++; $display("FAIL reset_cy got %0d want 0", cy); end
    if (nx !== 9'd1)  begin errors++; $display("FAIL reset_nx got %0d want 1", nx); end
    if (ny !== 9'd0)  begin errors++; $display("FAIL reset_ny got %0d want 0", ny); end
    if (hs !== 1'b1)  begin errors++; $display("FAIL reset_hsync got %b want 1", hs); end
    if (vs !== 1'b1)  begin errors++; $display("FAIL reset_vsync got %b want 1", vs); end
    if (vis !== 1'b1) begin errors++; $display("FAIL reset_visible got %b want 1", vis); end
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    if (fc !== 8'd0)  begin errors++; $display("FAIL reset_fc got %0d want 0", fc); end
    if (s_nx !== 9'd1) begin errors++; $display("FAIL reset_small_nx got %0d want 1", s_nx); end
    step(3);
    checks++;
    if (cx !== 9'd0) begin errors++; $display("FAIL reset_hold_cx got %0d want 0", cx); end
  endtask

  task automatic test_line;
    int bad_x, bad_nx, bad_hs, bad_vis, bad_y, bad_ny, hs_low, hs_first, x, row;
    logic [8:0] ey, eny, enx;
    logic ehs, evis;
    bad_x = 0; bad_nx = 0; bad_hs = 0; bad_vis = 0; bad_y = 0; bad_ny = 0;
    hs_low = 0; hs_first = -1;
    release_rst();
    for (int i = 0; i < 960; i++) begin
      x = i % 320;
      row = i / 320;
      enx = (x == 319) ? 9'd0 : 9'(x + 1);
      ehs = (x >= 264 && x <= 295) ? 1'b0 : 1'b1;
      evis = (x < 256) ? 1'b1 : 1'b0;
      ey = 9'(row / 2);
      eny = (row % 2 == 1) ? 9'(row / 2 + 1) : 9'(row / 2);
      if (cx !== 9'(x)) bad_x++;
      if (nx !== enx) bad_nx++;
      if (hs !== ehs) bad_hs++;
      if (vis !== evis) bad_vis++;
      if (cy !== ey) bad_y++;
      if (ny !== eny) bad_ny++;
      if (i < 320 && hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = x;
      end
      step(1);
    end
    checks += 9;
    if (bad_x != 0)    begin errors++; $display("FAIL line_cx bad_cycles %0d want 0", bad_x); end
    if (bad_nx != 0)   begin errors++; $display("FAIL line_nx bad_cycles %0d want 0", bad_nx); end
    if (bad_hs != 0)   begin errors++; $display("FAIL line_hsync bad_cycles %0d want 0", bad_hs); end
    if (bad_vis != 0)  begin errors++; $display("FAIL line_visible bad_cycles %0d want 0", bad_vis); end
    if (bad_y != 0)    begin errors++; $display("FAIL line_cy bad_cycles %0d want 0", bad_y); end
    if (bad_ny != 0)   begin errors++; $display("FAIL line_ny bad_cycles %0d want 0", bad_ny); end
    if (hs_low != 32)  begin errors++; $display("FAIL line_hsync_width got %0d want 32", hs_low); end
    if (hs_first != 264) begin errors++; $display("FAIL line_hsync_start got %0d want 264", hs_first); end
    if (cy !== 9'd1)   begin errors++; $display("FAIL line_row3_cy got %0d want 1", cy); end
  endtask

  task automatic test_midsync_reset;
    int n;
    step(270);
    checks++;
    if (hs !== 1'b0) begin errors++; $display("FAIL midsync_pre_hsync got %b want 0", hs); end
    async_reset();
    checks += 4;
    if (hs !== 1'b1)  begin errors++; $display("FAIL midsync_hsync got %b want 1", hs); end
    if (cx !== 9'd0)  begin errors++; $display("FAIL midsync_cx got %0d want 0", cx); end
    if (cy !== 9'd0)  begin errors++; $display("FAIL midsync_cy got %0d want 0", cy); end
    if (nx !== 9'd1)  begin errors++; $display("FAIL midsync_nx got %0d want 1", nx); end
    release_rst();
    n = 0;
    while (hs !== 1'b0 && n < 600) begin
      step(1);
      n++;
    end
    checks++;
    if (n != 264) begin errors++; $display("FAIL midsync_hsync_delay got %0d want 264", n); end
  endtask

  task automatic test_small_frame;
    int bad_x, bad_y, bad_nx, bad_ny, bad_hs, bad_vs, bad_vis, bad_irq;
    int vis_cnt, vs_cnt, irq_cnt, irq_pos, x, row, rep, y;
    logic [8:0] eny, enx;
    bad_x = 0; bad_y = 0; bad_nx = 0; bad_ny = 0; bad_hs = 0; bad_vs = 0;
    bad_vis = 0; bad_irq = 0; vis_cnt = 0; vs_cnt = 0; irq_cnt = 0; irq_pos = -1;
    async_reset();
    release_rst();
    for (int i = 0; i < S_FRAME; i++) begin
      x = i % SH_TOTAL;
      row = i / SH_TOTAL;
      rep = row % S_LR;
      y = row / S_LR;
      enx = (x == SH_TOTAL - 1) ? 9'd0 : 9'(x + 1);
      if (row == S_ROWS - 1) eny = 9'(S_MAXY);
      else if (rep == S_LR - 1) eny = 9'(y + 1);
      else eny = 9'(y);
      if (s_cx !== 9'(x)) bad_x++;
      if (s_cy !== 9'(y)) bad_y++;
      if (s_nx !== enx) bad_nx++;
      if (s_ny !== eny) bad_ny++;
      if (s_hs !== ((x >= SHS_START && x <= SHS_END) ? 1'b0 : 1'b1)) bad_hs++;
      if (s_vs !== ((row >= SVS_START && row <= SVS_END) ? 1'b0 : 1'b1)) bad_vs++;
      if (s_vis !== ((x < SH_VIS && row < S_VVIS) ? 1'b1 : 1'b0)) bad_vis++;
      if (s_irq !== ((x == 0 && row == S_VVIS) ? 1'b1 : 1'b0)) bad_irq++;
      if (s_vis === 1'b1) vis_cnt++;
      if (s_vs === 1'b0) vs_cnt++;
      if (s_irq === 1'b1) begin
        irq_cnt++;
        irq_pos = i;
      end
      step(1);
    end
    checks += 14;
    if (bad_x != 0)   begin errors++; $display("FAIL frame_cx bad_cycles %0d want 0", bad_x); end
    if (bad_y != 0)   begin errors++; $display("FAIL frame_cy bad_cycles %0d want 0", bad_y); end
    if (bad_nx != 0)  begin errors++; $display("FAIL frame_nx bad_cycles %0d want 0", bad_nx); end
    if (bad_ny != 0)  begin errors++; $display("FAIL frame_ny bad_cycles %0d want 0", bad_ny); end
    if (bad_hs != 0)  begin errors++; $display("FAIL frame_hsync bad_cycles %0d want 0", bad_hs); end
    if (bad_vs != 0)  begin errors++; $display("FAIL frame_vsync bad_cycles %0d want 0", bad_vs); end
    if (bad_vis != 0) begin errors++; $display("FAIL frame_visible bad_cycles %0d want 0", bad_vis); end
    if (bad_irq != 0) begin errors++; $display("FAIL frame_irq bad_cycles %0d want 0", bad_irq); end
    if (vis_cnt != 48) begin errors++; $display("FAIL frame_visible_count got %0d want 48", vis_cnt); end
    if (vs_cnt != 32)  begin errors++; $display("FAIL frame_vsync_count got %0d want 32", vs_cnt); end
    if (irq_cnt != 1)  begin errors++; $display("FAIL frame_irq_count got %0d want 1", irq_cnt); end
    if (irq_pos != 96) begin errors++; $display("FAIL frame_irq_pos got %0d want 96", irq_pos); end
    if (s_cx !== 9'd0 || s_cy !== 9'd0) begin
      errors++; $display("FAIL frame_wrap_pos got %0d,%0d want 0,0", s_cx, s_cy);
    end
    if (s_fc !== 8'd1) begin errors++; $display("FAIL frame_fc got %0d want 1", s_fc); end
  endtask

  task automatic test_frame_count;
    int irq_cnt;
    async_reset();
    release_rst();
    irq_cnt = 0;
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      if (s_irq === 1'b1) irq_cnt++;
      step(1);
    end
    checks += 2;
    if (irq_cnt != 3) begin errors++; $display("FAIL frames3_irq_count got %0d want 3", irq_cnt); end
    if (s_fc !== 8'd3) begin errors++; $display("FAIL frames3_fc got %0d want 3", s_fc); end
    // Position now 528; the 256th pulse lands at 255*176+96.
    step(255 * S_FRAME + 96 - 1 - 3 * S_FRAME);
    checks += 2;
    if (s_fc !== 8'd255) begin errors++; $display("FAIL wrap_fc_pre got %0d want 255", s_fc); end
    if (s_irq !== 1'b0)  begin errors++; $display("FAIL wrap_irq_pre got %b want 0", s_irq); end
    step(1);
    checks += 2;
    if (s_fc !== 8'd0)  begin errors++; $display("FAIL wrap_fc got %0d want 0", s_fc); end
    if (s_irq !== 1'b1) begin errors++; $display("FAIL wrap_irq got %b want 1", s_irq); end
  endtask

  task automatic test_small_vsync_reset;
    int n;
    async_reset();
    release_rst();
    step(8 * SH_TOTAL + 11);
    checks++;
    if (s_vs !== 1'b0 || s_hs !== 1'b0) begin
      errors++; $display("FAIL vreset_pre got vs=%b hs=%b want 0 0", s_vs, s_hs);
    end
    async_reset();
    checks += 3;
    if (s_vs !== 1'b1 || s_hs !== 1'b1) begin
      errors++; $display("FAIL vreset_sync got vs=%b hs=%b want 1 1", s_vs, s_hs);
    end
    if (s_cy !== 9'd0 || s_ny !== 9'd0) begin
      errors++; $display("FAIL vreset_y got cy=%0d ny=%0d want 0 0", s_cy, s_ny);
    end
    if (s_fc !== 8'd0 || s_vis !== 1'b1) begin
      errors++; $display("FAIL vreset_misc got fc=%0d vis=%b want 0 1", s_fc, s_vis);
    end
    release_rst();
    n = 0;
    while (s_hs !== 1'b0 && n < 100) begin
      step(1);
      n++;
    end
    checks++;
    if (n != SHS_START) begin errors++; $display("FAIL vreset_hsync_delay got %0d want %0d", n, SHS_START); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_midsync_reset();
    test_small_frame();
    test_frame_count();
    test_small_vsync_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
